// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C register-file target
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  // Bit counter runs 0..8: 0..7 while shifting, 8 once a byte is complete.
  localparam int                   BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = 4'd7;
  localparam logic [BIT_CNT_W-1:0] BIT_DONE  = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronisers with edge and START/STOP detection
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_ff;
  logic [SYNC_STAGES-1:0] sda_ff;
  logic                   scl_s;
  logic                   scl_q;
  logic                   sda_q;

  // Resynchronise both lines; reset to the idle-bus level so no false edge appears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_ff <= '1;
      sda_ff <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl};
      sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda};
      scl_q  <= scl_s;
      sda_q  <= sda_s;
    end
  end

  assign scl_s     = scl_ff[SYNC_STAGES-1];
  assign sda_s     = sda_ff[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  // SDA may only move while SCL is low, so an SDA edge with SCL high is a bus condition.
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C target with a pointer-addressed bank of 8-bit registers
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1110000,
  parameter int         NUM_REGS    = 8,
  parameter int         NUM_RW      = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           SCL,
  inout  wire                            SDA,
  output logic [NUM_RW*8-1:0]            ctrl_regs,
  input  logic [(NUM_REGS-NUM_RW)*8-1:0] status_regs,
  output logic                           wr_valid,
  output logic [$clog2(NUM_REGS)-1:0]    wr_idx,
  output logic [7:0]                     wr_data,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic                 sda_s;
  logic                 scl_rise;
  logic                 scl_fall;
  logic                 start_det;
  logic                 stop_det;

  i2c_state_t           state;
  i2c_state_t           state_n;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] cnt_n;
  logic [6:0]           shift;
  logic [6:0]           shift_n;
  logic [IDX_W-1:0]     pointer;
  logic [IDX_W-1:0]     ptr_n;
  logic [IDX_W-1:0]     ptr_inc;
  logic                 sda_oe;
  logic                 oe_n;
  logic                 rw;
  logic                 rw_n;
  logic                 wr_en;
  logic [7:0]           byte_in;
  logic [7:0]           rd_byte;
  logic [NUM_RW*8-1:0]  ctrl_q;
  logic [7:0]           regs_all [NUM_REGS];

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (SCL),
    .sda       (SDA),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Open-drain: only ever pull low or let go.
  assign SDA = sda_oe ? 1'b0 : 1'bz;

  // Unified read view: control registers first, status registers after them.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    if (g < NUM_RW) begin : g_rw
      assign regs_all[g] = ctrl_q[8*g +: 8];
    end else begin : g_ro
      assign regs_all[g] = status_regs[8*(g-NUM_RW) +: 8];
    end
  end

  assign rd_byte   = regs_all[pointer];
  assign byte_in   = {shift, sda_s};
  assign ptr_inc   = (int'(pointer) == NUM_REGS-1) ? '0 : pointer + IDX_W'(1);
  assign busy      = (state != ST_IDLE) && (state != ST_ADDR);
  assign ctrl_regs = ctrl_q;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state and datapath updates; bus conditions override every state.
  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    shift_n = shift;
    ptr_n   = pointer;
    oe_n    = sda_oe;
    rw_n    = rw;
    wr_en   = 1'b0;
    if (stop_det) begin
      state_n = ST_IDLE;
      oe_n    = 1'b0;
    end else if (start_det) begin
      state_n = ST_ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_ADDR: if (scl_rise) begin
          shift_n = byte_in[6:0];
          cnt_n   = bit_cnt + BIT_CNT_W'(1);
          if (bit_cnt == BIT_LAST) begin
            if (byte_in[7:1] == SLAVE_ADDR) begin
              state_n = ST_ADDR_ACK;
              rw_n    = byte_in[0];
            end else begin
              state_n = ST_IDLE;
            end
          end
        end
        // First SCL fall pulls SDA low for the ACK clock, second fall ends it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
          cnt_n = '0;
          if (bit_cnt == BIT_DONE) begin
            oe_n = 1'b1;
          end else begin
            oe_n = 1'b0;
            if (state != ST_ADDR_ACK) begin
              state_n = ST_WDATA;
            end else if (rw == I2C_RW_WRITE) begin
              state_n = ST_PTR;
            end else begin
              state_n = ST_RDATA;
              shift_n = rd_byte[6:0];
              oe_n    = ~rd_byte[7];
              ptr_n   = ptr_inc;
            end
          end
        end
        ST_PTR: if (scl_rise) begin
          shift_n = byte_in[6:0];
          cnt_n   = bit_cnt + BIT_CNT_W'(1);
          if (bit_cnt == BIT_LAST) begin
            if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
              ptr_n   = byte_in[IDX_W-1:0];
              state_n = ST_PTR_ACK;
            end else begin
              state_n = ST_IDLE;
            end
          end
        end
        ST_WDATA: if (scl_rise) begin
          shift_n = byte_in[6:0];
          cnt_n   = bit_cnt + BIT_CNT_W'(1);
          if (bit_cnt == BIT_LAST) begin
            wr_en   = (int'(pointer) < NUM_RW);
            ptr_n   = ptr_inc;
            state_n = ST_WDATA_ACK;
          end
        end
        ST_RDATA: if (scl_rise) begin
          cnt_n = bit_cnt + BIT_CNT_W'(1);
        end else if (scl_fall) begin
          if (bit_cnt == BIT_DONE) begin
            oe_n    = 1'b0;
            cnt_n   = '0;
            state_n = ST_RDATA_ACK;
          end else begin
            oe_n    = ~shift[6];
            shift_n = {shift[5:0], 1'b0};
          end
        end
        // Master ACK marks the counter; the following fall starts the next byte.
        ST_RDATA_ACK: if (scl_rise) begin
          if (sda_s) state_n = ST_IDLE;
          else       cnt_n   = BIT_DONE;
        end else if (scl_fall && bit_cnt == BIT_DONE) begin
          state_n = ST_RDATA;
          cnt_n   = '0;
          shift_n = rd_byte[6:0];
          oe_n    = ~rd_byte[7];
          ptr_n   = ptr_inc;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Datapath registers, control-register writes and the write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      shift    <= '0;
      pointer  <= '0;
      sda_oe   <= 1'b0;
      rw       <= 1'b0;
      ctrl_q   <= '0;
      wr_valid <= 1'b0;
      wr_idx   <= '0;
      wr_data  <= '0;
    end else begin
      bit_cnt  <= cnt_n;
      shift    <= shift_n;
      pointer  <= ptr_n;
      sda_oe   <= oe_n;
      rw       <= rw_n;
      wr_valid <= wr_en;
      if (wr_en) begin
        wr_idx  <= pointer;
        wr_data <= byte_in;
        for (int i = 0; i < NUM_RW; i++) begin
          if (pointer == IDX_W'(i)) ctrl_q[8*i +: 8] <= byte_in;
        end
      end
    end
  end

endmodule
